// File: rtl/control_setare.sv
// Clock/alarm set-mode sequencer: button sync + edge detect, edit FSM, load strobes.
// Optional inactivity abort compiled in with `define SETARE_TIMEOUT_EN.
module control_setare #(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 30000000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       btn_timp,
  input  logic       btn_alarma,
  input  logic       btn_ore,
  input  logic       btn_minute,
  input  logic       btn_stop,
  input  logic [4:0] ore_curent,
  input  logic [5:0] minute_curent,
  input  logic [4:0] ore_alarma,
  input  logic [5:0] minute_alarma,
  output logic [4:0] ore,
  output logic [5:0] minute,
  output logic       load_timp,
  output logic       load_alarma,
  output logic [1:0] mod,
  output logic       expirat
);

  typedef enum logic [1:0] {
    IDLE       = 2'b00,
    SET_TIMP   = 2'b01,
    SET_ALARMA = 2'b10,
    COMMIT     = 2'b11
  } state_e;

  localparam int ARM_N = SYNC_STAGES + 1;
  localparam int AW    = $clog2(ARM_N + 1);

  logic [4:0]                   btn_raw;
  logic [SYNC_STAGES-1:0][4:0]  sync_q;
  logic [4:0]                   edge_q;
  logic [AW-1:0]                arm_q;
  logic                         armed;
  logic [4:0]                   ev;
  logic ev_timp, ev_alarma, ev_ore, ev_minute, ev_stop;

  assign btn_raw = {btn_stop, btn_minute, btn_ore,
                    btn_alarma, btn_timp};

  assign armed = (arm_q == AW'(ARM_N));
  assign ev    = sync_q[SYNC_STAGES-1] & ~edge_q & {5{armed}};

  assign ev_timp   = ev[0];
  assign ev_alarma = ev[1];
  assign ev_ore    = ev[2];
  assign ev_minute = ev[3];
  assign ev_stop   = ev[4];

  // Arm counter masks edges from buttons already high at reset release.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
      edge_q <= '0;
      arm_q  <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], btn_raw};
      edge_q <= sync_q[SYNC_STAGES-1];
      if (!armed) arm_q <= arm_q + AW'(1);
    end
  end

  function automatic logic [4:0] inc_h(input logic [4:0] h);
    return (h >= 5'd23) ? 5'd0 : h + 5'd1;
  endfunction

  function automatic logic [5:0] inc_m(input logic [5:0] m);
    return (m >= 6'd59) ? 6'd0 : m + 6'd1;
  endfunction

  state_e     state_q, state_d;
  logic [4:0] ore_q, ore_d;
  logic [5:0] min_q, min_d;
  logic       lt_q, lt_d;
  logic       la_q, la_d;

`ifdef SETARE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] tmo_q, tmo_d;
  logic          exp_q, exp_d;
`else
  logic unused_tmo;
  assign unused_tmo = (TIMEOUT_CYCLES == 0);
`endif

  always_comb begin
    state_d = state_q;
    ore_d   = ore_q;
    min_d   = min_q;
    lt_d    = 1'b0;
    la_d    = 1'b0;
`ifdef SETARE_TIMEOUT_EN
    tmo_d   = tmo_q;
    exp_d   = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (ev_timp) begin
          state_d = SET_TIMP;
          ore_d   = ore_curent;
          min_d   = minute_curent;
`ifdef SETARE_TIMEOUT_EN
          tmo_d   = '0;
`endif
        end else if (ev_alarma) begin
          state_d = SET_ALARMA;
          ore_d   = ore_alarma;
          min_d   = minute_alarma;
`ifdef SETARE_TIMEOUT_EN
          tmo_d   = '0;
`endif
        end
      end
      SET_TIMP, SET_ALARMA: begin
        if (ev_stop) begin
          state_d = COMMIT;
          lt_d    = (state_q == SET_TIMP);
          la_d    = (state_q == SET_ALARMA);
`ifdef SETARE_TIMEOUT_EN
        end else if (tmo_q == TMO_LAST) begin
          state_d = IDLE;
          exp_d   = 1'b1;
`endif
        end else begin
          if (ev_ore)    ore_d = inc_h(ore_q);
          if (ev_minute) min_d = inc_m(min_q);
`ifdef SETARE_TIMEOUT_EN
          tmo_d = (ev_ore || ev_minute) ? '0
                                        : tmo_q + TW'(1);
`endif
        end
      end
      COMMIT: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ore_q   <= '0;
      min_q   <= '0;
      lt_q    <= 1'b0;
      la_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ore_q   <= ore_d;
      min_q   <= min_d;
      lt_q    <= lt_d;
      la_q    <= la_d;
    end
  end

`ifdef SETARE_TIMEOUT_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tmo_q <= '0;
      exp_q <= 1'b0;
    end else begin
      tmo_q <= tmo_d;
      exp_q <= exp_d;
    end
  end

  assign expirat = exp_q;
`else
  assign expirat = 1'b0;
`endif

  assign ore         = ore_q;
  assign minute      = min_q;
  assign load_timp   = lt_q;
  assign load_alarma = la_q;
  assign mod         = state_q;

endmodule

// File: tb/tb_control_setare.sv
// Bench for control_setare: pin-history reference model checked every cycle,
// edit table, and hand sequences for reset, simultaneity and commit corners.
module tb_control_setare;

  localparam int S = 2;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [4:0] pins  = '0;
  logic [4:0] ore_curent    = '0;
  logic [5:0] minute_curent = '0;
  logic [4:0] ore_alarma    = '0;
  logic [5:0] minute_alarma = '0;
  logic [4:0] ore;
  logic [5:0] minute;
  logic       load_timp, load_alarma, expirat;
  logic [1:0] mod;

  control_setare #(.SYNC_STAGES(S), .TIMEOUT_CYCLES(100)) dut (
    .clock         (clock),
    .reset         (reset),
    .btn_timp      (pins[0]),
    .btn_alarma    (pins[1]),
    .btn_ore       (pins[2]),
    .btn_minute    (pins[3]),
    .btn_stop      (pins[4]),
    .ore_curent    (ore_curent),
    .minute_curent (minute_curent),
    .ore_alarma    (ore_alarma),
    .minute_alarma (minute_alarma),
    .ore           (ore),
    .minute        (minute),
    .load_timp     (load_timp),
    .load_alarma   (load_alarma),
    .mod           (mod),
    .expirat       (expirat)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;
  int cnt_lt = 0;
  int cnt_la = 0;

  // Reference model: pin levels recorded per clock edge since reset release.
  logic [4:0] hist[$];
  int m_k, m_mode, m_ore, m_min;
  int m_lt, m_la;

  task automatic chk(string nm, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      if (bad <= 30)
        $display("FAIL %s got=%0d want=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [4:0] getp(int j);
    if (j < 1 || j > hist.size()) return 5'b0;
    return hist[j-1];
  endfunction

  task automatic model_reset();
    hist.delete();
    m_k = 0; m_mode = 0; m_ore = 0; m_min = 0;
    m_lt = 0; m_la = 0;
  endtask

  task automatic model_edge();
    logic [4:0] e;
    hist.push_back(pins);
    m_k++;
    e = getp(m_k - S) & ~getp(m_k - S - 1);
    if (m_k < S + 2) e = '0;
    m_lt = 0;
    m_la = 0;
    case (m_mode)
      0: begin
        if (e[0]) begin
          m_mode = 1; m_ore = ore_curent; m_min = minute_curent;
        end else if (e[1]) begin
          m_mode = 2; m_ore = ore_alarma; m_min = minute_alarma;
        end
      end
      1, 2: begin
        if (e[4]) begin
          m_lt = (m_mode == 1);
          m_la = (m_mode == 2);
          m_mode = 3;
        end else begin
          if (e[2]) m_ore = (m_ore >= 23) ? 0 : m_ore + 1;
          if (e[3]) m_min = (m_min >= 59) ? 0 : m_min + 1;
        end
      end
      default: m_mode = 0;
    endcase
  endtask

  task automatic tick();
    @(posedge clock);
    if (!reset) model_edge();
    #1;
    chk("mod", int'(mod), m_mode);
    chk("ore", int'(ore), m_ore);
    chk("minute", int'(minute), m_min);
    chk("load_timp", int'(load_timp), m_lt);
    chk("load_alarma", int'(load_alarma), m_la);
    chk("expirat", int'(expirat), 0);
    cnt_lt += int'(load_timp);
    cnt_la += int'(load_alarma);
  endtask

  task automatic do_reset();
    model_reset();
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
  endtask

  task automatic press(int b);
    pins[b] = 1'b1;
    repeat (4) tick();
    pins[b] = 1'b0;
    repeat (4) tick();
  endtask

  typedef struct {
    bit alarm;
    int ph, pm, nh, nm, eh, em;
  } vec_t;

  vec_t tbl[6];

  initial begin
    int nonidle;
    tbl[0] = '{0, 22, 58, 2, 3, 0, 1};
    tbl[1] = '{0, 23, 59, 1, 1, 0, 0};
    tbl[2] = '{1, 25, 61, 1, 1, 0, 0};
    tbl[3] = '{1, 7, 30, 0, 0, 7, 30};
    tbl[4] = '{0, 10, 20, 5, 7, 15, 27};
    tbl[5] = '{1, 23, 0, 25, 61, 0, 1};

    // T1: timp held through reset release never fires
    pins = 5'b00001;
    do_reset();
    chk("reset_mod", int'(mod), 0);
    chk("reset_ore", int'(ore), 0);
    nonidle = 0;
    cnt_lt = 0; cnt_la = 0;
    repeat (50) begin
      tick();
      if (mod != 2'b00) nonidle++;
    end
    chk("t1_nonidle", nonidle, 0);
    chk("t1_strobes", cnt_lt + cnt_la, 0);
    pins = '0;
    repeat (4) tick();

    // T2
    ore_curent = 5'd22; minute_curent = 6'd58;
    cnt_lt = 0; cnt_la = 0;
    press(0);
    chk("t2_mod_set", int'(mod), 1);
    repeat (2) press(2);
    repeat (3) press(3);
    press(4);
    chk("t2_ore", int'(ore), 0);
    chk("t2_min", int'(minute), 1);
    chk("t2_lt_cnt", cnt_lt, 1);
    chk("t2_la_cnt", cnt_la, 0);
    chk("t2_mod", int'(mod), 0);

    // T3: hours and minutes on the same edge
    ore_alarma = 5'd7; minute_alarma = 6'd30;
    cnt_lt = 0; cnt_la = 0;
    press(1);
    chk("t3_mod_set", int'(mod), 2);
    pins[2] = 1'b1; pins[3] = 1'b1;
    repeat (4) tick();
    pins = '0;
    repeat (4) tick();
    press(4);
    chk("t3_ore", int'(ore), 8);
    chk("t3_min", int'(minute), 31);
    chk("t3_la_cnt", cnt_la, 1);
    chk("t3_lt_cnt", cnt_lt, 0);

    // T4: stop beats minute on the same edge
    ore_curent = 5'd10; minute_curent = 6'd20;
    cnt_lt = 0; cnt_la = 0;
    press(0);
    pins[4] = 1'b1; pins[3] = 1'b1;
    repeat (4) tick();
    pins = '0;
    repeat (4) tick();
    chk("t4_min", int'(minute), 20);
    chk("t4_lt_cnt", cnt_lt, 1);

    // T5: asynchronous reset while editing an alarm
    ore_alarma = 5'd5; minute_alarma = 6'd45;
    press(1);
    press(2);
    chk("t5_mod_set", int'(mod), 2);
    chk("t5_ore_set", int'(ore), 6);
    #3 reset = 1'b1;
    #1;
    chk("t5_async_mod", int'(mod), 0);
    chk("t5_async_ore", int'(ore), 0);
    chk("t5_async_min", int'(minute), 0);
    chk("t5_async_ld", int'(load_timp | load_alarma), 0);
    model_reset();
    repeat (2) tick();
    reset = 1'b0;
    cnt_lt = 0; cnt_la = 0;
    repeat (20) tick();
    chk("t5_no_strobe", cnt_lt + cnt_la, 0);

    // T6 (default build): set state persists without input
    press(0);
    repeat (150) tick();
    chk("t6_mod", int'(mod), 1);
    chk("t6_expirat", int'(expirat), 0);
    press(4);

    // Edit table
    foreach (tbl[i]) begin
      if (tbl[i].alarm) begin
        ore_alarma = 5'(tbl[i].ph); minute_alarma = 6'(tbl[i].pm);
      end else begin
        ore_curent = 5'(tbl[i].ph); minute_curent = 6'(tbl[i].pm);
      end
      cnt_lt = 0; cnt_la = 0;
      press(tbl[i].alarm ? 1 : 0);
      repeat (tbl[i].nh) press(2);
      repeat (tbl[i].nm) press(3);
      press(4);
      chk($sformatf("tbl%0d_ore", i), int'(ore), tbl[i].eh);
      chk($sformatf("tbl%0d_min", i), int'(minute), tbl[i].em);
      chk($sformatf("tbl%0d_ld", i),
          tbl[i].alarm ? cnt_la : cnt_lt, 1);
    end

    // Random pin activity against the model
    repeat (4000) begin
      for (int b = 0; b < 5; b++)
        if ($urandom_range(0, 5) == 0) pins[b] = ~pins[b];
      if ($urandom_range(0, 40) == 0) begin
        ore_curent    = 5'($urandom_range(0, 31));
        minute_curent = 6'($urandom_range(0, 63));
        ore_alarma    = 5'($urandom_range(0, 31));
        minute_alarma = 6'($urandom_range(0, 63));
      end
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
